// File: rtl/wb_commit_queue.sv
// -----------------------------------------------------------------------------
// wb_commit_queue
//
// Writeback stage for the MIPS pipeline. Each request picks a result source:
// ALU result, extracted load data, link PC, or zero. Sub-word loads are
// shifted into place, truncated and extended to the datapath width. Results
// that write a real register are queued in a DEPTH-entry FIFO. The FIFO drains
// in order to the register-file write port under a ready handshake. Every
// queued result can be found by the forwarding unit through an address lookup.
//
// Parameters
//   DATA_WIDTH      datapath width (multiple of 8, >= 32)
//   REG_ADDR_WIDTH  register address width
//   DEPTH           queue entries (power of 2, >= 2)
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   in_valid         writeback request from the MEM/WB register
//   in_ready         stage can accept (queue not full)
//   mem_to_reg       source select: 0 ALU, 1 load, 2 PC, 3 zero
//   reg_write        request writes a register
//   write_reg        destination register
//   alu_result       ALU result operand
//   read_data        raw load data
//   pc               link PC operand
//   load_type        0 word, 1 half s, 2 half u, 3 byte s, 4 byte u, 5-7 word
//   byte_offset      byte lane of the load (little-endian)
//   rf_write_enable  head entry valid
//   rf_write_addr    head destination (0 when empty)
//   rf_write_data    head data (0 when empty)
//   rf_ready         register file accepts the head this cycle
//   fwd_addr         forwarding query address
//   fwd_hit          a queued entry targets fwd_addr
//   fwd_data         data of the youngest matching entry (0 on miss)
//   pending          number of occupied entries
// -----------------------------------------------------------------------------
module wb_commit_queue #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 4,
    localparam int OFF_W         = $clog2(DATA_WIDTH / 8),
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int CNT_W         = PTR_W + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                mem_to_reg,
    input  logic                      reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic [DATA_WIDTH-1:0]     pc,
    input  logic [2:0]                load_type,
    input  logic [OFF_W-1:0]          byte_offset,
    output logic                      rf_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    input  logic                      rf_ready,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_addr,
    output logic                      fwd_hit,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [CNT_W-1:0]          pending
);

    // -------------------------------------------------------------------------
    // Result selection and load extraction
    // -------------------------------------------------------------------------
    logic [OFF_W+2:0]      shift_amt;
    logic [DATA_WIDTH-1:0] load_shifted;
    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] result_value;

    assign shift_amt    = {byte_offset, 3'b000};
    assign load_shifted = read_data >> shift_amt;

    always_comb begin
        load_value = read_data;
        case (load_type)
            3'd1:    load_value = {{(DATA_WIDTH-16){load_shifted[15]}}, load_shifted[15:0]};
            3'd2:    load_value = {{(DATA_WIDTH-16){1'b0}},             load_shifted[15:0]};
            3'd3:    load_value = {{(DATA_WIDTH-8){load_shifted[7]}},   load_shifted[7:0]};
            3'd4:    load_value = {{(DATA_WIDTH-8){1'b0}},              load_shifted[7:0]};
            // Word loads (and unused encodings) ignore the byte offset.
            default: load_value = read_data;
        endcase
    end

    always_comb begin
        result_value = '0;
        case (mem_to_reg)
            2'd0:    result_value = alu_result;
            2'd1:    result_value = load_value;
            2'd2:    result_value = pc;
            default: result_value = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Queue control
    // -------------------------------------------------------------------------
    logic [REG_ADDR_WIDTH-1:0] addr_mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem_reg [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg;
    logic [CNT_W-1:0]          count_next;

    logic accept;
    logic push;
    logic pop;
    logic head_valid;

    // in_ready depends only on registered occupancy, never on rf_ready, so a
    // full queue refuses a push even in a cycle where it also pops.
    assign in_ready   = (count_reg != CNT_W'(DEPTH));
    assign accept     = in_valid && in_ready;
    // Requests that do not write a real register are consumed and dropped.
    assign push       = accept && reg_write && (write_reg != '0);
    assign head_valid = (count_reg != '0);
    assign pop        = head_valid && rf_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Entry storage. Kept in flops, not block RAM, because the forwarding
    // lookup must see every entry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_reg[i] <= '0;
                data_mem_reg[i] <= '0;
            end
        end else if (push) begin
            addr_mem_reg[wr_ptr_reg] <= write_reg;
            data_mem_reg[wr_ptr_reg] <= result_value;
        end
    end

    // -------------------------------------------------------------------------
    // Register-file port: the head entry, forced to zero when empty
    // -------------------------------------------------------------------------
    assign rf_write_enable = head_valid;
    assign rf_write_addr   = head_valid ? addr_mem_reg[rd_ptr_reg] : '0;
    assign rf_write_data   = head_valid ? data_mem_reg[rd_ptr_reg] : '0;
    assign pending         = count_reg;

    // -------------------------------------------------------------------------
    // Forwarding lookup
    // Entries are viewed in age order: age 0 is the head (oldest), and higher
    // ages are younger. Only ages below the occupancy count are live.
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0]      age_match;
    logic [DATA_WIDTH-1:0] age_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] slot;
            assign slot          = rd_ptr_reg + PTR_W'(gi);
            assign age_match[gi] = (CNT_W'(gi) < count_reg) &&
                                   (addr_mem_reg[slot] == fwd_addr);
            assign age_data[gi]  = data_mem_reg[slot];
        end
    endgenerate

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        // The scan runs from oldest to youngest, so the last match wins.
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = age_data[i];
            end
        end
        // Register 0 is hard-wired, so a query for it never hits.
        if (fwd_addr == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

endmodule

// File: tb/tb_wb_commit_queue.sv
module tb_wb_commit_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc;
    logic [2:0]  load_type;
    logic [1:0]  byte_offset;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_ready;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  pending;

    int tests_run;
    int tests_failed;

    wb_commit_queue #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5),
        .DEPTH         (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_to_reg     (mem_to_reg),
        .reg_write      (reg_write),
        .write_reg      (write_reg),
        .alu_result     (alu_result),
        .read_data      (read_data),
        .pc             (pc),
        .load_type      (load_type),
        .byte_offset    (byte_offset),
        .rf_write_enable(rf_write_enable),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_ready       (rf_ready),
        .fwd_addr       (fwd_addr),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (pending !== 3'd0 || in_ready !== 1'b1 || rf_write_enable !== 1'b0 ||
            rf_write_addr !== 5'd0 || rf_write_data !== 32'd0 ||
            fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: pending=%0d in_ready=%b we=%b addr=%0d data=%h hit=%b fdata=%h, required 0 1 0 0 0 0 0",
                     pending, in_ready, rf_write_enable, rf_write_addr, rf_write_data, fwd_hit, fwd_data);
        end
        #1;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_source_select;
        logic [31:0] exp_data [4];
        exp_data[0] = 32'h0000_0011;
        exp_data[1] = 32'h0000_0022;
        exp_data[2] = 32'h0040_0008;
        exp_data[3] = 32'h0000_0000;
        rf_ready   = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd8;
        alu_result = 32'h11;
        read_data  = 32'h22;
        pc         = 32'h0040_0008;
        load_type  = 3'd0;
        byte_offset = 2'd0;
        in_valid   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_to_reg = 2'(k);
            tick;
            tests_run++;
            if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd8 || rf_write_data !== exp_data[k]) begin
                tests_failed++;
                $display("FAIL src_sel_%0d: we=%b addr=%0d data=%h, required 1 8 %h",
                         k, rf_write_enable, rf_write_addr, rf_write_data, exp_data[k]);
            end else begin
                $display("[TB] src_sel %0d: RF $%0d <= %h", k, rf_write_addr, rf_write_data);
            end
        end
        in_valid = 1'b0;
        tick;
        tests_run++;
        if (rf_write_enable !== 1'b0 || pending !== 3'd0) begin
            tests_failed++;
            $display("FAIL src_sel_drained: we=%b pending=%0d, required 0 0", rf_write_enable, pending);
        end
    endtask

    task automatic test_load_extract;
        logic [2:0]  lt  [8];
        logic [1:0]  off [8];
        logic [31:0] exp [8];
        lt[0] = 3'd3; off[0] = 2'd0; exp[0] = 32'hFFFF_FF82;
        lt[1] = 3'd3; off[1] = 2'd1; exp[1] = 32'h0000_007F;
        lt[2] = 3'd3; off[2] = 2'd2; exp[2] = 32'hFFFF_FFF1;
        lt[3] = 3'd3; off[3] = 2'd3; exp[3] = 32'hFFFF_FF80;
        lt[4] = 3'd2; off[4] = 2'd2; exp[4] = 32'h0000_80F1;
        lt[5] = 3'd1; off[5] = 2'd0; exp[5] = 32'h0000_7F82;
        lt[6] = 3'd4; off[6] = 2'd0; exp[6] = 32'h0000_0082;
        lt[7] = 3'd0; off[7] = 2'd3; exp[7] = 32'h80F1_7F82;
        rf_ready   = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd12;
        mem_to_reg = 2'd1;
        read_data  = 32'h80F1_7F82;
        in_valid   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            load_type   = lt[k];
            byte_offset = off[k];
            tick;
            tests_run++;
            if (rf_write_enable !== 1'b1 || rf_write_data !== exp[k]) begin
                tests_failed++;
                $display("FAIL load_%0d (type %0d off %0d): we=%b data=%h, required 1 %h",
                         k, lt[k], off[k], rf_write_enable, rf_write_data, exp[k]);
            end else begin
                $display("[TB] load type %0d off %0d: RF $%0d <= %h", lt[k], off[k], rf_write_addr, rf_write_data);
            end
        end
        in_valid    = 1'b0;
        load_type   = 3'd0;
        byte_offset = 2'd0;
        tick;
    endtask

    task automatic test_backpressure;
        logic [4:0] exp_head [4];
        logic [2:0] exp_pend [4];
        exp_head[0] = 5'd2; exp_pend[0] = 3'd3;
        exp_head[1] = 5'd3; exp_pend[1] = 3'd3;
        exp_head[2] = 5'd4; exp_pend[2] = 3'd2;
        exp_head[3] = 5'd5; exp_pend[3] = 3'd1;
        rf_ready   = 1'b0;
        reg_write  = 1'b1;
        mem_to_reg = 2'd0;
        in_valid   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            write_reg  = 5'(k);
            alu_result = 32'h100 + k;
            tick;
        end
        write_reg  = 5'd5;
        alu_result = 32'h105;
        tick;
        tests_run++;
        if (in_ready !== 1'b0 || pending !== 3'd4 || rf_write_addr !== 5'd1 || rf_write_data !== 32'h101) begin
            tests_failed++;
            $display("FAIL full: in_ready=%b pending=%0d head=%0d data=%h, required 0 4 1 00000101",
                     in_ready, pending, rf_write_addr, rf_write_data);
        end
        rf_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_no_comb_ready: in_ready=%b, required 0", in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            if (k == 1) in_valid = 1'b0;
            tests_run++;
            if (rf_write_enable !== 1'b1 || rf_write_addr !== exp_head[k] ||
                rf_write_data !== (32'h100 + 32'(exp_head[k])) || pending !== exp_pend[k] || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain_%0d: we=%b head=%0d data=%h pending=%0d in_ready=%b, required 1 %0d %h %0d 1",
                         k, rf_write_enable, rf_write_addr, rf_write_data, pending, in_ready,
                         exp_head[k], 32'h100 + 32'(exp_head[k]), exp_pend[k]);
            end else begin
                $display("[TB] drain: RF $%0d <= %h", rf_write_addr, rf_write_data);
            end
        end
        tick;
        tests_run++;
        if (rf_write_enable !== 1'b0 || pending !== 3'd0) begin
            tests_failed++;
            $display("FAIL drain_empty: we=%b pending=%0d, required 0 0", rf_write_enable, pending);
        end
    endtask

    task automatic test_filter;
        rf_ready   = 1'b1;
        mem_to_reg = 2'd0;
        alu_result = 32'hDEAD;
        in_valid   = 1'b1;
        reg_write  = 1'b0;
        write_reg  = 5'd7;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL filter_ready: in_ready=%b, required 1", in_ready);
        end
        tick;
        tests_run++;
        if (pending !== 3'd0 || rf_write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL filter_nowrite: pending=%0d we=%b, required 0 0", pending, rf_write_enable);
        end
        reg_write = 1'b1;
        write_reg = 5'd0;
        tick;
        tests_run++;
        if (pending !== 3'd0 || rf_write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL filter_r0: pending=%0d we=%b, required 0 0", pending, rf_write_enable);
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_forwarding;
        rf_ready   = 1'b0;
        reg_write  = 1'b1;
        mem_to_reg = 2'd0;
        in_valid   = 1'b1;
        write_reg  = 5'd9;
        alu_result = 32'hA;
        fwd_addr   = 5'd9;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL fwd_incoming_invisible: hit=%b data=%h, required 0 0", fwd_hit, fwd_data);
        end
        tick;
        write_reg  = 5'd3;
        alu_result = 32'hB;
        tick;
        write_reg  = 5'd9;
        alu_result = 32'hC;
        tick;
        in_valid = 1'b0;
        fwd_addr = 5'd9;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'hC) begin
            tests_failed++;
            $display("FAIL fwd_youngest: hit=%b data=%h, required 1 0000000c", fwd_hit, fwd_data);
        end
        fwd_addr = 5'd3;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin
            tests_failed++;
            $display("FAIL fwd_r3: hit=%b data=%h, required 1 0000000b", fwd_hit, fwd_data);
        end
        fwd_addr = 5'd0;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL fwd_r0: hit=%b data=%h, required 0 0", fwd_hit, fwd_data);
        end
        fwd_addr = 5'd4;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL fwd_miss: hit=%b data=%h, required 0 0", fwd_hit, fwd_data);
        end
        // Drain: duplicates to $9 must both be written, in order.
        fwd_addr = 5'd9;
        rf_ready = 1'b1;
        tests_run++;
        if (rf_write_addr !== 5'd9 || rf_write_data !== 32'hA) begin
            tests_failed++;
            $display("FAIL fwd_drain0: head=%0d data=%h, required 9 0000000a", rf_write_addr, rf_write_data);
        end
        tick;
        tests_run++;
        if (rf_write_addr !== 5'd3 || rf_write_data !== 32'hB || fwd_hit !== 1'b1 || fwd_data !== 32'hC) begin
            tests_failed++;
            $display("FAIL fwd_drain1: head=%0d data=%h hit=%b fdata=%h, required 3 0000000b 1 0000000c",
                     rf_write_addr, rf_write_data, fwd_hit, fwd_data);
        end
        tick;
        tests_run++;
        if (rf_write_addr !== 5'd9 || rf_write_data !== 32'hC) begin
            tests_failed++;
            $display("FAIL fwd_drain2: head=%0d data=%h, required 9 0000000c", rf_write_addr, rf_write_data);
        end
        tick;
        tests_run++;
        if (rf_write_enable !== 1'b0 || fwd_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_drained: we=%b hit=%b, required 0 0", rf_write_enable, fwd_hit);
        end
    endtask

    task automatic test_reset_mid;
        rf_ready   = 1'b0;
        reg_write  = 1'b1;
        mem_to_reg = 2'd0;
        in_valid   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            write_reg  = 5'(10 + k);
            alu_result = 32'h200 + k;
            tick;
        end
        in_valid = 1'b0;
        fwd_addr = 5'd11;
        #1;
        tests_run++;
        if (pending !== 3'd3 || fwd_hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_setup: pending=%0d hit=%b, required 3 1", pending, fwd_hit);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (pending !== 3'd0 || in_ready !== 1'b1 || rf_write_enable !== 1'b0 ||
            rf_write_addr !== 5'd0 || rf_write_data !== 32'd0 ||
            fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: pending=%0d in_ready=%b we=%b addr=%0d data=%h hit=%b fdata=%h, required 0 1 0 0 0 0 0",
                     pending, in_ready, rf_write_enable, rf_write_addr, rf_write_data, fwd_hit, fwd_data);
        end
        #1;
        rst_n    = 1'b1;
        rf_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            tests_run++;
            if (rf_write_enable !== 1'b0 || pending !== 3'd0) begin
                tests_failed++;
                $display("FAIL rst_mid_nowrite_%0d: we=%b pending=%0d, required 0 0", k, rf_write_enable, pending);
            end
        end
        in_valid   = 1'b1;
        write_reg  = 5'd13;
        alu_result = 32'h300;
        tick;
        in_valid = 1'b0;
        tests_run++;
        if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd13 || rf_write_data !== 32'h300) begin
            tests_failed++;
            $display("FAIL rst_mid_first_accept: we=%b addr=%0d data=%h, required 1 13 00000300",
                     rf_write_enable, rf_write_addr, rf_write_data);
        end
        tick;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        mem_to_reg   = 2'd0;
        reg_write    = 1'b0;
        write_reg    = 5'd0;
        alu_result   = 32'd0;
        read_data    = 32'd0;
        pc           = 32'd0;
        load_type    = 3'd0;
        byte_offset  = 2'd0;
        rf_ready     = 1'b0;
        fwd_addr     = 5'd0;

        test_reset;
        test_source_select;
        test_load_extract;
        test_backpressure;
        test_filter;
        test_forwarding;
        test_reset_mid;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Parametrised writeback stage for the MIPS pipeline. It selects the result source (ALU, load data, link PC, zero), extracts and extends sub-word load data, and queues completed writebacks in a DEPTH-entry FIFO. The FIFO drains to a register-file write port under a ready handshake. Queued results are exposed to the forwarding unit through an address-match lookup port.

## Interface
- DATA_WIDTH, 32, datapath width; multiple of 8, ≥ 32
- REG_ADDR_WIDTH, 5, register address width
- DEPTH, 4, queue entries; power of 2, ≥ 2
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- In_Valid  in  1  writeback request from MEM/WB register
- In_Ready  out  1  stage can accept; equals (Pending != DEPTH)
- MemToReg  in  2  source select: 0 ALUResult, 1 load data, 2 PC, 3 zero
- RegWrite  in  1  request writes a register
- WriteReg  in  REG_ADDR_WIDTH  destination register
- ALUResult, ReadData, PC  in  DATA_WIDTH  source operands
- LoadType  in  3  0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned, 5–7 treated as word
- ByteOffset  in  log2(DATA_WIDTH/8)  byte lane of load (little-endian)
- RF_WriteEnable  out  1  head entry valid
- RF_WriteAddr  out  REG_ADDR_WIDTH  head destination
- RF_WriteData  out  DATA_WIDTH  head data
- RF_Ready  in  1  register file accepts head this cycle
- Fwd_Addr  in  REG_ADDR_WIDTH  forwarding query address
- Fwd_Hit  out  1  a queued entry targets Fwd_Addr
- Fwd_Data  out  DATA_WIDTH  data of youngest matching entry
- Pending  out  log2(DEPTH)+1  occupied entries

## Operation
- Accept: In_Valid && In_Ready at a rising edge.
- Result: MemToReg selects the source. Load data (MemToReg=1) is ReadData shifted right by 8·ByteOffset. It is then truncated to 16 or 8 bits per LoadType, and sign- or zero-extended to DATA_WIDTH. For word loads, ByteOffset is ignored.
- Enqueue: an accepted request is enqueued only if RegWrite=1 and WriteReg≠0. Otherwise it is accepted and discarded with no state change.
- Drain: when RF_WriteEnable && RF_Ready, the head is popped at the edge.
- RF_* outputs are driven combinationally from the head entry. When empty, all RF_* outputs are 0.
- Simultaneous push and pop: allowed at any occupancy below DEPTH; Pending is unchanged. At Pending=DEPTH, In_Ready=0, so no push occurs even if a pop happens that cycle. No combinational RF_Ready→In_Ready path.
- Pointers wrap modulo DEPTH.
- Forwarding lookup:
  - Combinational across all valid entries; the youngest match wins.
  - Fwd_Addr=0 gives Fwd_Hit=0.
  - On a miss, Fwd_Data=0.
  - The request being accepted this cycle is not visible to the lookup.
- Ordering: writes leave in strict acceptance order. Duplicates to the same register are all written; none are coalesced.

## Timing
- Latency: accepted at edge N → RF_WriteEnable=1 from edge N (visible during cycle N+1). Minimum one cycle; no bypass.
- Throughput: one accept and one drain per cycle.
- Reset asserted (Reset=0), asynchronously:
  - Pending=0, pointers=0, all entries invalid.
  - RF_WriteEnable=0, RF_WriteAddr=0, RF_WriteData=0, Fwd_Hit=0, Fwd_Data=0.
  - In_Ready=1.
- Reset mid-operation: queued entries are lost without being written. The first accept after deassertion is honoured at the first rising edge with Reset=1.
- Full: Pending=DEPTH → In_Ready=0. In_Ready returns to 1 in the cycle after a pop.
- Empty with RF_Ready=1: no pop, no underflow.

## Test plan
- Source select: WriteReg=8, ALUResult=0x11, ReadData=0x22, PC=0x0040_0008, MemToReg=0/1/2/3 on consecutive cycles, RF_Ready=1 → RF writes to $8 of 0x11, 0x22, 0x0040_0008, 0x0 in order, each one cycle after accept.
- Load extraction: ReadData=0x80F1_7F82. Byte signed at offsets 0/1/2/3 → 0xFFFF_FF82, 0x0000_007F, 0xFFFF_FFF1, 0xFFFF_FF80. Half unsigned at offset 2 → 0x0000_80F1. Half signed at offset 0 → 0x0000_7F82.
- Backpressure and full: RF_Ready=0, five back-to-back requests to $1..$5 → $1..$4 accepted, In_Ready=0, Pending=4. Raise RF_Ready → $1..$4 drain in order, then $5 is accepted and written.
- Filtering: RegWrite=0, or WriteReg=0 with RegWrite=1 → accepted, Pending stays 0, RF_WriteEnable stays 0.
- Forwarding: RF_Ready=0. Queue $9=0xA, then $3=0xB, then $9=0xC. Fwd_Addr=9 → Hit=1, Data=0xC. Fwd_Addr=3 → Data=0xB. Fwd_Addr=0 or 4 → Hit=0, Data=0.
- Reset mid-drain: three entries queued, assert Reset=0 between edges → all outputs 0 immediately, In_Ready=1, no further RF writes after release.
